// File: rtl/subvq_senone_logadd.sv
// subvq_senone_logadd
//   Takes per-component Gaussian scores from the shortlist stage, adds each
//   component's log mixture weight and log-adds the weighted scores into one
//   senone score (logs3, base 1.0001). It also tracks the best component.
//
// Ports
//   i_clk, i_rst                    clock (rising edge), async active-low reset
//   i_start, i_n, i_wbase           begin a senone: component count, weight base
//   i_score, i_score_ready          upstream component score and valid
//   o_score_received                one-cycle registered acknowledge to upstream
//   i_wr_en, i_wr_addr, i_wr_data   mixture-weight memory write port
//   o_senone_score, o_best_idx      result, stable while o_senone_valid is high
//   o_senone_valid, i_senone_ack    result handshake
module subvq_senone_logadd #(
    parameter int data_width    = 32,
    parameter int address_width = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [data_width-1:0]        i_n,
    input  logic [address_width-1:0]     i_wbase,
    input  logic signed [data_width-1:0] i_score,
    input  logic                         i_score_ready,
    output logic                         o_score_received,
    input  logic                         i_wr_en,
    input  logic [address_width-1:0]     i_wr_addr,
    input  logic signed [data_width-1:0] i_wr_data,
    output logic signed [data_width-1:0] o_senone_score,
    output logic [data_width-1:0]        o_best_idx,
    output logic                         o_senone_valid,
    input  logic                         i_senone_ack
);

    localparam logic signed [data_width-1:0] LOGZERO = data_width'(signed'(32'hC8000000));
    localparam logic signed [data_width:0]   LZ_EXT  = {LOGZERO[data_width-1], LOGZERO};
    localparam logic signed [data_width:0]   MAX_EXT = {2'b00, {(data_width-1){1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_ACC, S_DONE} state_t;

    state_t                        r_state;
    logic [data_width-1:0]         r_n;
    logic [address_width-1:0]      r_wbase;
    logic [data_width-1:0]         r_i;
    logic signed [data_width-1:0]  r_score;
    logic signed [data_width-1:0]  r_w;
    logic signed [data_width-1:0]  r_acc;
    logic signed [data_width-1:0]  r_best_s;
    logic [data_width-1:0]         r_best_idx;
    logic                          r_rcv;
    logic                          r_valid;

    logic signed [data_width-1:0]  r_mem [0:(1<<address_width)-1];

    logic [address_width-1:0]      w_raddr;
    logic signed [data_width:0]    w_sum;
    logic signed [data_width-1:0]  w_s;
    logic signed [data_width:0]    w_diff;
    logic [data_width:0]           w_d;
    logic [data_width:0]           w_k;
    logic signed [data_width:0]    w_hi;
    logic signed [data_width:0]    w_corr;
    logic signed [data_width:0]    w_la_ext;
    logic signed [data_width-1:0]  w_la;

    // Weight address wraps naturally at address_width bits.
    assign w_raddr = r_wbase + r_i[address_width-1:0];

    // Weight RAM: not reset, read-before-write on an address collision.
    // The read is only enabled when a score is captured, so the weight held
    // in r_w belongs to the component being accumulated.
    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        if (r_state == S_WAIT && i_score_ready)
            r_w <= r_mem[w_raddr];
    end

    function automatic logic signed [data_width:0] corr_tab(input logic [2:0] k);
        case (k)
            3'd0:    corr_tab = (data_width+1)'(6931);
            3'd1:    corr_tab = (data_width+1)'(5092);
            3'd2:    corr_tab = (data_width+1)'(3652);
            3'd3:    corr_tab = (data_width+1)'(2567);
            3'd4:    corr_tab = (data_width+1)'(1776);
            3'd5:    corr_tab = (data_width+1)'(1213);
            3'd6:    corr_tab = (data_width+1)'(821);
            default: corr_tab = (data_width+1)'(553);
        endcase
    endfunction

    always_comb begin
        // Weighted score, widened by one bit so the floor clamp sees the true sum.
        w_sum = {r_score[data_width-1], r_score} + {r_w[data_width-1], r_w};
        if (r_score == LOGZERO || r_w == LOGZERO || w_sum < LZ_EXT)
            w_s = LOGZERO;
        else if (w_sum > MAX_EXT)
            w_s = MAX_EXT[data_width-1:0];
        else
            w_s = w_sum[data_width-1:0];

        // Log-add of accumulator and weighted score.
        w_diff = {r_acc[data_width-1], r_acc} - {w_s[data_width-1], w_s};
        w_d    = w_diff[data_width] ? unsigned'(-w_diff) : unsigned'(w_diff);
        w_hi   = w_diff[data_width] ? {w_s[data_width-1], w_s} : {r_acc[data_width-1], r_acc};
        w_k    = w_d >> 12;
        w_corr = (w_k < 8) ? corr_tab(w_k[2:0]) : '0;
        w_la_ext = w_hi + w_corr;
        if (r_acc == LOGZERO)
            w_la = w_s;
        else if (w_s == LOGZERO)
            w_la = r_acc;
        else if (w_la_ext > MAX_EXT)
            w_la = MAX_EXT[data_width-1:0];
        else
            w_la = w_la_ext[data_width-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_wbase    <= '0;
            r_i        <= '0;
            r_score    <= '0;
            r_acc      <= '0;
            r_best_s   <= '0;
            r_best_idx <= '0;
            r_rcv      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_rcv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_n        <= i_n;
                        r_wbase    <= i_wbase;
                        r_i        <= '0;
                        r_best_idx <= '0;
                        r_best_s   <= LOGZERO;
                        if (i_n == '0) begin
                            r_acc   <= LOGZERO;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_score_ready) begin
                        r_score <= i_score;
                        r_rcv   <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: r_state <= S_ACC;
                S_ACC: begin
                    r_acc <= (r_i == '0) ? w_s : w_la;
                    // Strict compare keeps the lowest index on a tie.
                    if (r_i == '0 || w_s > r_best_s) begin
                        r_best_s   <= w_s;
                        r_best_idx <= r_i;
                    end
                    if (r_i == r_n - 1'b1) begin
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i     <= r_i + 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    if (i_senone_ack) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_score_received = r_rcv;
    assign o_senone_valid   = r_valid;
    assign o_senone_score   = r_acc;
    assign o_best_idx       = r_best_idx;

endmodule

// File: tb/tb_subvq_senone_logadd.sv
// Directed bench for subvq_senone_logadd: hand-computed log-add results,
// latency, handshake and reset behaviour.
module tb_subvq_senone_logadd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] n_in;
    logic [7:0]  wbase;
    logic [31:0] score;
    logic        score_ready;
    logic        score_received;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] senone_score;
    logic [31:0] best_idx;
    logic        senone_valid;
    logic        senone_ack;

    subvq_senone_logadd #(.data_width(32), .address_width(8)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_n              (n_in),
        .i_wbase          (wbase),
        .i_score          (score),
        .i_score_ready    (score_ready),
        .o_score_received (score_received),
        .i_wr_en          (wr_en),
        .i_wr_addr        (wr_addr),
        .i_wr_data        (wr_data),
        .o_senone_score   (senone_score),
        .o_best_idx       (best_idx),
        .o_senone_valid   (senone_valid),
        .i_senone_ack     (senone_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] sc [0:3];
    logic [31:0] res_score;
    logic [31:0] res_idx;
    int          res_lat;
    int          res_rcv;
    int          res_got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Runs one senone acting as the upstream: holds score_ready until
    // acknowledged, drops it in the ack cycle, raises it again with the next
    // score. Stops at the first cycle senone_valid is seen (res_lat counts
    // cycles after the start cycle).
    task automatic run(input logic [31:0] n, input logic [7:0] wb);
        int k;
        k           = 0;
        start       = 1'b1;
        n_in        = n;
        wbase       = wb;
        score_ready = (n != 0);
        score       = sc[0];
        tick();
        start   = 1'b0;
        res_lat = 1;
        res_rcv = 0;
        res_got = 0;
        for (int c = 0; c < 100; c++) begin
            if (senone_valid) begin
                res_got   = 1;
                res_score = senone_score;
                res_idx   = best_idx;
                break;
            end
            if (score_received) begin
                res_rcv++;
                k++;
                score_ready = 1'b0;
            end else if (k < int'(n) && !score_ready) begin
                score_ready = 1'b1;
                score       = sc[k];
            end
            tick();
            res_lat++;
        end
        score_ready = 1'b0;
        chk("valid_seen", 32'(res_got), 32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; n_in = '0; wbase = '0; score = '0;
        score_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        senone_ack = 1'b1;
        #12;
        chk("rst_rcv",   32'(score_received), 32'd0);
        chk("rst_valid", 32'(senone_valid),   32'd0);
        chk("rst_score", senone_score,        32'd0);
        chk("rst_idx",   best_idx,            32'd0);
        rst = 1'b1;
        tick();

        // n=1: -5000 + -100
        wr(8'd0, 32'(-100));
        sc[0] = 32'(-5000);
        run(32'd1, 8'd0);
        chk("t1_score", res_score, 32'(-5100));
        chk("t1_idx",   res_idx,   32'd0);
        chk("t1_lat",   32'(res_lat), 32'd4);
        chk("t1_rcv",   32'(res_rcv), 32'd1);
        tick();
        chk("t1_valid_1cyc", 32'(senone_valid), 32'd0);

        // d=0 tie: -1000 + 6931
        wr(8'd10, 32'd0);
        wr(8'd11, 32'd0);
        sc[0] = 32'(-1000); sc[1] = 32'(-1000);
        run(32'd2, 8'd10);
        chk("t2_score", res_score, 32'd5931);
        chk("t2_idx",   res_idx,   32'd0);
        chk("t2_rcv",   32'(res_rcv), 32'd2);
        chk("t2_lat",   32'(res_lat), 32'd7);
        tick();

        // d=29000, k=7: -1000 + 553
        sc[0] = 32'(-30000); sc[1] = 32'(-1000);
        run(32'd2, 8'd10);
        chk("t3_score", res_score, 32'(-447));
        chk("t3_idx",   res_idx,   32'd1);
        tick();

        // d=49000, k=11: no correction
        sc[0] = 32'(-1000); sc[1] = 32'(-50000);
        run(32'd2, 8'd10);
        chk("t3b_score", res_score, 32'(-1000));
        chk("t3b_idx",   res_idx,   32'd0);
        tick();

        // n=0
        run(32'd0, 8'd3);
        chk("t4_lat",   32'(res_lat), 32'd1);
        chk("t4_rcv",   32'(res_rcv), 32'd0);
        chk("t4_score", res_score, 32'hC8000000);
        chk("t4_idx",   res_idx,   32'd0);
        tick();

        // ack held low: results held, start and score_ready ignored
        wr(8'd0, 32'(-100));
        senone_ack = 1'b0;
        sc[0] = 32'(-5000);
        run(32'd1, 8'd0);
        chk("t6_score", res_score, 32'(-5100));
        score_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            n_in  = 32'd0;
            tick();
            chk("t6_hold_valid", 32'(senone_valid),   32'd1);
            chk("t6_hold_score", senone_score,        32'(-5100));
            chk("t6_hold_idx",   best_idx,            32'd0);
            chk("t6_hold_rcv",   32'(score_received), 32'd0);
        end
        start = 1'b0;
        score_ready = 1'b0;
        senone_ack = 1'b1;
        tick();
        chk("t6_released", 32'(senone_valid), 32'd0);
        tick();
        chk("t6_no_restart", 32'(senone_valid), 32'd0);

        // Floor clamp and address wrap: LOGZERO-5 -> LOGZERO, -20-7 = -27
        wr(8'd255, 32'(-5));
        wr(8'd0,   32'(-7));
        sc[0] = 32'hC8000000; sc[1] = 32'(-20);
        run(32'd2, 8'd255);
        chk("t5_score", res_score, 32'(-27));
        chk("t5_idx",   res_idx,   32'd1);
        tick();

        // Reset in READ, then a clean senone
        wr(8'd20, 32'(-10));
        sc[0] = 32'(-2000);
        start = 1'b1; n_in = 32'd1; wbase = 8'd20; score = sc[0]; score_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t7_rcv_pre", 32'(score_received), 32'd1);
        score_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_rcv",   32'(score_received), 32'd0);
        chk("t7_rst_valid", 32'(senone_valid),   32'd0);
        chk("t7_rst_score", senone_score,        32'd0);
        chk("t7_rst_idx",   best_idx,            32'd0);
        #2 rst = 1'b1;
        tick();
        run(32'd1, 8'd20);
        chk("t7_score", res_score, 32'(-2010));
        chk("t7_idx",   res_idx,   32'd0);
        chk("t7_lat",   32'(res_lat), 32'd4);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
